hazard_unit: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It generates the 2-bit forwarding selects that drive the EX-stage operand mux4 instances (srcA and srcB), and the 1-bit ID-stage branch-compare forwards. It produces stall/flush controls for load-use and branch-compare hazards. It also owns a sequential FSM that holds the pipeline while the multi-cycle divider in EX runs.

---
 rtl/hazard_unit_pkg.sv | 19 +
 rtl/hazard_unit_if.sv | 45 ++++
 rtl/hazard_unit_div_stall_fsm.sv | 58 +++++
 rtl/hazard_unit.sv | 80 ++++++++
 tb/tb_hazard_unit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the MIPS pipeline hazard logic: forward-select encodings,
// the default register-index width and the divider-stall FSM state type.
package mips_defs;

    localparam int unsigned REG_W = 5;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } div_state_e;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle. master = datapath side, slave = hazard unit.
interface hazard_unit_if #(
    parameter int unsigned REG_W = mips_defs::REG_W
);
    logic [REG_W-1:0] rsD;
    logic [REG_W-1:0] rtD;
    logic [REG_W-1:0] rsE;
    logic [REG_W-1:0] rtE;
    logic [REG_W-1:0] writeregE;
    logic [REG_W-1:0] writeregM;
    logic [REG_W-1:0] writeregW;
    logic             regwriteE;
    logic             regwriteM;
    logic             regwriteW;
    logic             memtoregE;
    logic             memtoregM;
    logic             branchD;
    logic             div_startE;

    logic [1:0]       forwardAE;
    logic [1:0]       forwardBE;
    logic             forwardAD;
    logic             forwardBD;
    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             flushE;
    logic             flushM;
    logic             div_busy;

    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, div_startE,
        input  forwardAE, forwardBE, forwardAD, forwardBD,
               stallF, stallD, stallE, flushE, flushM, div_busy
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, div_startE,
        output forwardAE, forwardBE, forwardAD, forwardBD,
               stallF, stallD, stallE, flushE, flushM, div_busy
    );

endinterface

// File: rtl/hazard_unit_div_stall_fsm.sv
// Holds the pipeline while the multi-cycle EX divider runs: IDLE -> BUSY (DIV_CYCLES) -> DONE.
module div_stall_fsm
    import mips_defs::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic i_div_start,
    output logic o_divstall,
    output logic o_div_busy
);

    localparam int unsigned CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

    div_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_div_start) begin
                        r_state <= StBusy;
                        r_cnt   <= CNT_W'(DIV_CYCLES - 1);
                        r_busy  <= 1'b1;
                    end
                end
                StBusy: begin
                    if (r_cnt == '0) begin
                        r_state <= StDone;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                // Same div is still in EX here, so a held start must not retrigger.
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Entry is decoded combinationally so the first div cycle already stalls.
    assign o_divstall = ~rst & (((r_state == StIdle) & i_div_start) | (r_state == StBusy));
    assign o_div_busy = r_busy;

endmodule

// File: rtl/hazard_unit.sv
// MIPS 5-stage hazard controller: EX/ID forwarding selects, load-use and branch
// stalls, and the divider hold.
module hazard_unit
    import mips_defs::*;
#(
    parameter int unsigned REG_W      = mips_defs::REG_W,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_unit_if.slave  hz
);

    function automatic fwd_sel_t ex_fwd(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] wr_m,
        input logic             we_m,
        input logic [REG_W-1:0] wr_w,
        input logic             we_w
    );
        fwd_sel_t sel;
        sel = FWD_REG;
        if (src != '0 && we_m && wr_m == src) begin
            sel = FWD_MEM;
        end else if (src != '0 && we_w && wr_w == src) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    fwd_sel_t w_fwd_ae;
    fwd_sel_t w_fwd_be;
    logic     w_fwd_ad;
    logic     w_fwd_bd;
    logic     w_lwstall;
    logic     w_branchstall;
    logic     w_divstall;
    logic     w_div_busy;
    logic     w_stall_fd;

    always_comb begin
        w_fwd_ae = ex_fwd(hz.rsE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
        w_fwd_be = ex_fwd(hz.rtE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
        w_fwd_ad = (hz.rsD != '0) && hz.regwriteM && (hz.writeregM == hz.rsD);
        w_fwd_bd = (hz.rtD != '0) && hz.regwriteM && (hz.writeregM == hz.rtD);
    end

    always_comb begin
        w_lwstall     = hz.memtoregE && ((hz.rsD == hz.rtE) || (hz.rtD == hz.rtE));
        w_branchstall = hz.branchD &&
            ((hz.regwriteE && (hz.writeregE != '0) &&
              ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD))) ||
             (hz.memtoregM && ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD))));
        w_stall_fd    = w_lwstall | w_branchstall | w_divstall;
    end

    div_stall_fsm #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_fsm (
        .clk         (clk),
        .rst         (rst),
        .i_div_start (hz.div_startE),
        .o_divstall  (w_divstall),
        .o_div_busy  (w_div_busy)
    );

    // Reset forces every output low regardless of the stage inputs.
    assign hz.forwardAE = rst ? FWD_REG : w_fwd_ae;
    assign hz.forwardBE = rst ? FWD_REG : w_fwd_be;
    assign hz.forwardAD = ~rst & w_fwd_ad;
    assign hz.forwardBD = ~rst & w_fwd_bd;
    assign hz.stallF    = ~rst & w_stall_fd;
    assign hz.stallD    = ~rst & w_stall_fd;
    assign hz.stallE    = ~rst & w_divstall;
    assign hz.flushM    = ~rst & w_divstall;
    // EX contents belong to the divider while it holds them; never bubble them.
    assign hz.flushE    = ~rst & (w_lwstall | w_branchstall) & ~w_divstall;
    assign hz.div_busy  = ~rst & w_div_busy;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit with DIV_CYCLES=4.
module tb_hazard_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    hazard_unit_if #(.REG_W(5)) hz_if ();

    hazard_unit #(
        .REG_W      (5),
        .DIV_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        hz_if.rsD = '0; hz_if.rtD = '0; hz_if.rsE = '0; hz_if.rtE = '0;
        hz_if.writeregE = '0; hz_if.writeregM = '0; hz_if.writeregW = '0;
        hz_if.regwriteE = 1'b0; hz_if.regwriteM = 1'b0; hz_if.regwriteW = 1'b0;
        hz_if.memtoregE = 1'b0; hz_if.memtoregM = 1'b0;
        hz_if.branchD = 1'b0; hz_if.div_startE = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        // Reset held with inputs that would otherwise fire everything
        hz_if.rsE = 5'd8; hz_if.writeregM = 5'd8; hz_if.regwriteM = 1'b1;
        hz_if.rsD = 5'd8; hz_if.memtoregE = 1'b1; hz_if.rtE = 5'd8; hz_if.div_startE = 1'b1;
        step(); step(); #1;
        chk("rst_fwdAE", hz_if.forwardAE, 2'b00);
        chk("rst_fwdAD", {1'b0, hz_if.forwardAD}, 2'b00);
        chk("rst_stallF", {1'b0, hz_if.stallF}, 2'b00);
        chk("rst_flushE", {1'b0, hz_if.flushE}, 2'b00);
        chk("rst_stallE", {1'b0, hz_if.stallE}, 2'b00);
        chk("rst_busy", {1'b0, hz_if.div_busy}, 2'b00);

        step(); clear_inputs(); rst = 1'b0;

        // M beats W; rtE unmatched
        step();
        hz_if.writeregM = 5'd8; hz_if.regwriteM = 1'b1;
        hz_if.writeregW = 5'd8; hz_if.regwriteW = 1'b1;
        hz_if.rsE = 5'd8; hz_if.rtE = 5'd9; #1;
        chk("fwdAE_mem", hz_if.forwardAE, 2'b10);
        chk("fwdBE_none", hz_if.forwardBE, 2'b00);
        chk("no_stall", {1'b0, hz_if.stallF}, 2'b00);

        step(); hz_if.regwriteM = 1'b0; #1;
        chk("fwdAE_wb", hz_if.forwardAE, 2'b01);

        step(); hz_if.rtE = 5'd8; #1;
        chk("fwdBE_wb", hz_if.forwardBE, 2'b01);

        // Register 0 never forwards
        step();
        hz_if.writeregM = 5'd0; hz_if.regwriteM = 1'b1; hz_if.rsE = 5'd0;
        hz_if.writeregW = 5'd0; hz_if.rsD = 5'd0; #1;
        chk("fwdAE_r0", hz_if.forwardAE, 2'b00);
        chk("fwdAD_r0", {1'b0, hz_if.forwardAD}, 2'b00);

        step(); hz_if.writeregM = 5'd8; hz_if.rsD = 5'd8; hz_if.rtD = 5'd8; #1;
        chk("fwdAD_hit", {1'b0, hz_if.forwardAD}, 2'b01);
        chk("fwdBD_hit", {1'b0, hz_if.forwardBD}, 2'b01);

        // Load-use
        step(); clear_inputs();
        hz_if.memtoregE = 1'b1; hz_if.rtE = 5'd5; hz_if.rsD = 5'd5; #1;
        chk("lw_stallF", {1'b0, hz_if.stallF}, 2'b01);
        chk("lw_stallD", {1'b0, hz_if.stallD}, 2'b01);
        chk("lw_flushE", {1'b0, hz_if.flushE}, 2'b01);
        chk("lw_stallE", {1'b0, hz_if.stallE}, 2'b00);
        chk("lw_flushM", {1'b0, hz_if.flushM}, 2'b00);

        step(); hz_if.rsD = 5'd6; hz_if.rtD = 5'd7; #1;
        chk("lw_miss_stallD", {1'b0, hz_if.stallD}, 2'b00);
        chk("lw_miss_flushE", {1'b0, hz_if.flushE}, 2'b00);

        // Branch compare vs ALU result in EX, then load in MEM
        step(); clear_inputs();
        hz_if.branchD = 1'b1; hz_if.regwriteE = 1'b1; hz_if.writeregE = 5'd3; hz_if.rtD = 5'd3; #1;
        chk("br_e_stallD", {1'b0, hz_if.stallD}, 2'b01);
        chk("br_e_flushE", {1'b0, hz_if.flushE}, 2'b01);
        chk("br_e_stallF", {1'b0, hz_if.stallF}, 2'b01);

        step(); hz_if.regwriteE = 1'b0; hz_if.memtoregM = 1'b1; hz_if.writeregM = 5'd3; #1;
        chk("br_m_stallD", {1'b0, hz_if.stallD}, 2'b01);
        chk("br_m_flushE", {1'b0, hz_if.flushE}, 2'b01);

        // Load-use together with branch stall: still a single 1-bit stall/flush
        step(); hz_if.memtoregE = 1'b1; hz_if.rtE = 5'd3; #1;
        chk("both_stallD", {1'b0, hz_if.stallD}, 2'b01);
        chk("both_flushE", {1'b0, hz_if.flushE}, 2'b01);

        // Branch vs writeregE=0 must not stall
        step(); clear_inputs();
        hz_if.branchD = 1'b1; hz_if.regwriteE = 1'b1; hz_if.writeregE = 5'd0; #1;
        chk("br_r0_stallD", {1'b0, hz_if.stallD}, 2'b00);

        // Divider hold with a concurrent load-use hazard: cycle 0 IDLE, 1-4 BUSY, 5 DONE
        step(); clear_inputs();
        hz_if.memtoregE = 1'b1; hz_if.rtE = 5'd5; hz_if.rsD = 5'd5;
        begin
            int stall_cnt = 0;
            int busy_cnt = 0;
            for (int c = 0; c < 8; c++) begin
                if (c != 0) step();
                hz_if.div_startE = (c <= 5);
                #1;
                if (hz_if.stallE) stall_cnt++;
                if (hz_if.div_busy) busy_cnt++;
                chk($sformatf("div_stallE_c%0d", c), {1'b0, hz_if.stallE}, {1'b0, c <= 4});
                chk($sformatf("div_flushM_c%0d", c), {1'b0, hz_if.flushM}, {1'b0, c <= 4});
                chk($sformatf("div_busy_c%0d", c), {1'b0, hz_if.div_busy},
                    {1'b0, (c >= 1) && (c <= 5)});
                chk($sformatf("div_flushE_c%0d", c), {1'b0, hz_if.flushE}, {1'b0, c >= 5});
                chk($sformatf("div_stallF_c%0d", c), {1'b0, hz_if.stallF}, 2'b01);
            end
            chk("div_stall_total", stall_cnt[1:0], 2'(5));
            checks++;
            assert (stall_cnt == 5 && busy_cnt == 5) else begin
                errors++;
                $error("FAIL div_totals: observed stall=%0d busy=%0d expected 5/5",
                       stall_cnt, busy_cnt);
            end
        end

        // Reset in the 2nd BUSY cycle
        step(); clear_inputs();
        hz_if.writeregM = 5'd8; hz_if.regwriteM = 1'b1; hz_if.rsE = 5'd8;
        hz_if.div_startE = 1'b1; #1;
        chk("rb_c0_stallE", {1'b0, hz_if.stallE}, 2'b01);
        chk("rb_c0_fwdAE", hz_if.forwardAE, 2'b10);
        step(); #1;
        chk("rb_c1_busy", {1'b0, hz_if.div_busy}, 2'b01);
        step(); #1;
        chk("rb_c2_busy_pre", {1'b0, hz_if.div_busy}, 2'b01);
        rst = 1'b1; #1;
        chk("rb_rst_stallE", {1'b0, hz_if.stallE}, 2'b00);
        chk("rb_rst_stallF", {1'b0, hz_if.stallF}, 2'b00);
        chk("rb_rst_flushM", {1'b0, hz_if.flushM}, 2'b00);
        chk("rb_rst_busy", {1'b0, hz_if.div_busy}, 2'b00);
        chk("rb_rst_fwdAE", hz_if.forwardAE, 2'b00);
        step(); rst = 1'b0; hz_if.div_startE = 1'b0; #1;
        chk("rb_rel_busy", {1'b0, hz_if.div_busy}, 2'b00);
        chk("rb_rel_stallE", {1'b0, hz_if.stallE}, 2'b00);
        chk("rb_rel_fwdAE", hz_if.forwardAE, 2'b10);
        step(); step(); #1;
        chk("rb_idle_busy", {1'b0, hz_if.div_busy}, 2'b00);
        chk("rb_idle_stallE", {1'b0, hz_if.stallE}, 2'b00);

        // Fresh div restarts cleanly from IDLE
        step(); hz_if.div_startE = 1'b1; #1;
        chk("re_c0_stallE", {1'b0, hz_if.stallE}, 2'b01);
        chk("re_c0_busy", {1'b0, hz_if.div_busy}, 2'b00);
        step(); #1;
        chk("re_c1_busy", {1'b0, hz_if.div_busy}, 2'b01);
        chk("re_c1_stallE", {1'b0, hz_if.stallE}, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
